// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: commits WB-stage exceptions and ERTN as a fixed sequence
// of single-cycle CSR writes, followed by a one-cycle fetch redirect.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   wb_ex, ertn_flush               commit requests (exception wins)
//   wb_pc, wb_ecode, wb_esubcode,
//   wb_vaddr                        exception details from WB
//   csr_crmd_plv/ie, csr_prmd_pplv/pie,
//   csr_eentry, csr_era             current CSR values, sampled on accept
//   ctl_csr_we/num/wvalue/wmask     CSR write port, one write per write state
//   flush, busy                     high in every non-IDLE state
//   redirect_valid, redirect_pc     one-cycle fetch redirect
module exc_commit_ctrl #(
    parameter logic [13:0] CSR_CRMD  = 14'h0,
    parameter logic [13:0] CSR_PRMD  = 14'h1,
    parameter logic [13:0] CSR_ESTAT = 14'h5,
    parameter logic [13:0] CSR_ERA   = 14'h6,
    parameter logic [13:0] CSR_BADV  = 14'h7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_ex,
    input  logic        ertn_flush,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_vaddr,
    input  logic [1:0]  csr_crmd_plv,
    input  logic        csr_crmd_ie,
    input  logic [1:0]  csr_prmd_pplv,
    input  logic        csr_prmd_pie,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        ctl_csr_we,
    output logic [13:0] ctl_csr_num,
    output logic [31:0] ctl_csr_wvalue,
    output logic [31:0] ctl_csr_wmask,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    typedef enum logic [2:0] {
        IDLE,
        S_ERA,
        S_PRMD,
        S_ESTAT,
        S_BADV,
        S_CRMD,
        S_RCRMD,
        S_REDIR
    } state_e;

    state_e      state_q, state_d;

    // Snapshot of the committing request; frozen while the sequence runs so
    // the block's own CSR writes cannot feed back into later writes.
    logic [31:0] snap_pc_q,       snap_pc_d;
    logic [5:0]  snap_ecode_q,    snap_ecode_d;
    logic [8:0]  snap_esubcode_q, snap_esubcode_d;
    logic [1:0]  snap_plv_q,      snap_plv_d;
    logic        snap_ie_q,       snap_ie_d;
    logic [31:0] snap_eentry_q,   snap_eentry_d;
    logic [31:0] snap_badv_q,     snap_badv_d;
    logic        need_badv_q,     need_badv_d;
    logic [1:0]  snap_pplv_q,     snap_pplv_d;
    logic        snap_pie_q,      snap_pie_d;
    logic [31:0] snap_era_q,      snap_era_d;
    logic        is_ertn_q,       is_ertn_d;

    // State and snapshot registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            snap_pc_q       <= '0;
            snap_ecode_q    <= '0;
            snap_esubcode_q <= '0;
            snap_plv_q      <= '0;
            snap_ie_q       <= 1'b0;
            snap_eentry_q   <= '0;
            snap_badv_q     <= '0;
            need_badv_q     <= 1'b0;
            snap_pplv_q     <= '0;
            snap_pie_q      <= 1'b0;
            snap_era_q      <= '0;
            is_ertn_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            snap_pc_q       <= snap_pc_d;
            snap_ecode_q    <= snap_ecode_d;
            snap_esubcode_q <= snap_esubcode_d;
            snap_plv_q      <= snap_plv_d;
            snap_ie_q       <= snap_ie_d;
            snap_eentry_q   <= snap_eentry_d;
            snap_badv_q     <= snap_badv_d;
            need_badv_q     <= need_badv_d;
            snap_pplv_q     <= snap_pplv_d;
            snap_pie_q      <= snap_pie_d;
            snap_era_q      <= snap_era_d;
            is_ertn_q       <= is_ertn_d;
        end
    end

    // Next state, snapshot capture and output decode from registered state
    always_comb begin
        state_d         = state_q;
        snap_pc_d       = snap_pc_q;
        snap_ecode_d    = snap_ecode_q;
        snap_esubcode_d = snap_esubcode_q;
        snap_plv_d      = snap_plv_q;
        snap_ie_d       = snap_ie_q;
        snap_eentry_d   = snap_eentry_q;
        snap_badv_d     = snap_badv_q;
        need_badv_d     = need_badv_q;
        snap_pplv_d     = snap_pplv_q;
        snap_pie_d      = snap_pie_q;
        snap_era_d      = snap_era_q;
        is_ertn_d       = is_ertn_q;

        ctl_csr_we      = 1'b0;
        ctl_csr_num     = '0;
        ctl_csr_wvalue  = '0;
        ctl_csr_wmask   = '0;
        flush           = 1'b1;
        busy            = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;

        unique case (state_q)
            IDLE: begin
                flush = 1'b0;
                busy  = 1'b0;
                if (wb_ex) begin
                    state_d         = S_ERA;
                    is_ertn_d       = 1'b0;
                    snap_pc_d       = wb_pc;
                    snap_ecode_d    = wb_ecode;
                    snap_esubcode_d = wb_esubcode;
                    snap_plv_d      = csr_crmd_plv;
                    snap_ie_d       = csr_crmd_ie;
                    snap_eentry_d   = csr_eentry;
                    // Instruction-fetch faults report the PC as the bad address
                    snap_badv_d     = (wb_ecode == ECODE_ADEF) ? wb_pc : wb_vaddr;
                    need_badv_d     = (wb_ecode == ECODE_ADEF) || (wb_ecode == ECODE_ALE);
                end else if (ertn_flush) begin
                    state_d     = S_RCRMD;
                    is_ertn_d   = 1'b1;
                    snap_pplv_d = csr_prmd_pplv;
                    snap_pie_d  = csr_prmd_pie;
                    snap_era_d  = csr_era;
                end
            end
            S_ERA: begin
                state_d        = S_PRMD;
                ctl_csr_we     = 1'b1;
                ctl_csr_num    = CSR_ERA;
                ctl_csr_wvalue = snap_pc_q;
                ctl_csr_wmask  = 32'hFFFF_FFFF;
            end
            S_PRMD: begin
                state_d        = S_ESTAT;
                ctl_csr_we     = 1'b1;
                ctl_csr_num    = CSR_PRMD;
                ctl_csr_wvalue = {29'b0, snap_ie_q, snap_plv_q};
                ctl_csr_wmask  = 32'h0000_0007;
            end
            S_ESTAT: begin
                state_d        = need_badv_q ? S_BADV : S_CRMD;
                ctl_csr_we     = 1'b1;
                ctl_csr_num    = CSR_ESTAT;
                ctl_csr_wvalue = {1'b0, snap_esubcode_q, snap_ecode_q, 16'b0};
                ctl_csr_wmask  = 32'h7FFF_0000;
            end
            S_BADV: begin
                state_d        = S_CRMD;
                ctl_csr_we     = 1'b1;
                ctl_csr_num    = CSR_BADV;
                ctl_csr_wvalue = snap_badv_q;
                ctl_csr_wmask  = 32'hFFFF_FFFF;
            end
            S_CRMD: begin
                // Enter kernel mode with interrupts disabled
                state_d        = S_REDIR;
                ctl_csr_we     = 1'b1;
                ctl_csr_num    = CSR_CRMD;
                ctl_csr_wvalue = 32'h0;
                ctl_csr_wmask  = 32'h0000_0007;
            end
            S_RCRMD: begin
                state_d        = S_REDIR;
                ctl_csr_we     = 1'b1;
                ctl_csr_num    = CSR_CRMD;
                ctl_csr_wvalue = {29'b0, snap_pie_q, snap_pplv_q};
                ctl_csr_wmask  = 32'h0000_0007;
            end
            S_REDIR: begin
                state_d        = IDLE;
                redirect_valid = 1'b1;
                redirect_pc    = is_ertn_q ? snap_era_q : snap_eentry_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: a reference model turns each accepted
// request into the list of CSR writes and redirect it must produce (with the
// cycle each must appear in); a negedge monitor pops and compares.
module tb_exc_commit_ctrl;

    localparam logic [13:0] N_CRMD  = 14'h0;
    localparam logic [13:0] N_PRMD  = 14'h1;
    localparam logic [13:0] N_ESTAT = 14'h5;
    localparam logic [13:0] N_ERA   = 14'h6;
    localparam logic [13:0] N_BADV  = 14'h7;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_ex, ertn_flush;
    logic [31:0] wb_pc, wb_vaddr, csr_eentry, csr_era;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [1:0]  csr_crmd_plv, csr_prmd_pplv;
    logic        csr_crmd_ie, csr_prmd_pie;
    logic        ctl_csr_we, flush, redirect_valid, busy;
    logic [13:0] ctl_csr_num;
    logic [31:0] ctl_csr_wvalue, ctl_csr_wmask, redirect_pc;

    exc_commit_ctrl dut (
        .clk(clk), .resetn(resetn), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
        .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_vaddr(wb_vaddr), .csr_crmd_plv(csr_crmd_plv), .csr_crmd_ie(csr_crmd_ie),
        .csr_prmd_pplv(csr_prmd_pplv), .csr_prmd_pie(csr_prmd_pie),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .ctl_csr_we(ctl_csr_we), .ctl_csr_num(ctl_csr_num),
        .ctl_csr_wvalue(ctl_csr_wvalue), .ctl_csr_wmask(ctl_csr_wmask),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redir;
        logic [13:0] num;
        logic [31:0] val;
        logic [31:0] mask;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  rem = 0;
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void push(input bit r, input logic [13:0] n, input logic [31:0] v,
                                 input logic [31:0] m, input int c);
        ev_t e;
        e.redir = r; e.num = n; e.val = v; e.mask = m; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    // Reference model: on acceptance, list every effect with its cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (rem > 0) begin
                rem--;
            end else if (wb_ex) begin
                int k;
                k = 0;
                push(0, N_ERA, wb_pc, 32'hFFFFFFFF, cyc + k); k++;
                push(0, N_PRMD, 32'(csr_crmd_ie) * 4 + 32'(csr_crmd_plv), 32'h7, cyc + k); k++;
                push(0, N_ESTAT, 32'(wb_esubcode) * 32'h400000 + 32'(wb_ecode) * 32'h10000,
                     32'h7FFF0000, cyc + k); k++;
                if (wb_ecode == 6'h08) begin
                    push(0, N_BADV, wb_pc, 32'hFFFFFFFF, cyc + k); k++;
                end else if (wb_ecode == 6'h09) begin
                    push(0, N_BADV, wb_vaddr, 32'hFFFFFFFF, cyc + k); k++;
                end
                push(0, N_CRMD, 32'h0, 32'h7, cyc + k); k++;
                push(1, 14'h0, csr_eentry, 32'h0, cyc + k); k++;
                rem = k;
            end else if (ertn_flush) begin
                push(0, N_CRMD, 32'(csr_prmd_pie) * 4 + 32'(csr_prmd_pplv), 32'h7, cyc);
                push(1, 14'h0, csr_era, 32'h0, cyc + 1);
                rem = 2;
            end
        end
    end

    // Monitor: sample away from the active edge and check against the queue.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(rem > 0));
        check("flush", 32'(flush), 32'(rem > 0));
        if (ctl_csr_we) begin
            if (exp_q.size() != 0 && !exp_q[0].redir) begin
                check("csr_num", 32'(ctl_csr_num), 32'(exp_q[0].num));
                check("csr_wvalue", ctl_csr_wvalue, exp_q[0].val);
                check("csr_wmask", ctl_csr_wmask, exp_q[0].mask);
                check("csr_write_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end else begin
                check("unexpected_csr_write_num", 32'(ctl_csr_num), 32'hFFFFFFFF);
            end
        end else begin
            check("csr_fields_zero", 32'(ctl_csr_num) | ctl_csr_wvalue | ctl_csr_wmask, 32'h0);
        end
        if (redirect_valid) begin
            if (exp_q.size() != 0 && exp_q[0].redir) begin
                check("redirect_pc", redirect_pc, exp_q[0].val);
                check("redirect_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end else begin
                check("unexpected_redirect_pc", redirect_pc, 32'hFFFFFFFF);
            end
        end else begin
            check("redirect_pc_zero", redirect_pc, 32'h0);
        end
    end

    task automatic rand_inputs();
        int pick;
        wb_ex = 1'b0; ertn_flush = 1'b0;
        wb_pc = $urandom; wb_vaddr = $urandom;
        pick = $urandom_range(0, 3);
        wb_ecode = (pick == 0) ? 6'h08 : (pick == 1) ? 6'h09 : (pick == 2) ? 6'h0B
                 : 6'($urandom_range(0, 63));
        wb_esubcode = 9'($urandom_range(0, 511));
        csr_crmd_plv = 2'($urandom_range(0, 3)); csr_crmd_ie = 1'($urandom_range(0, 1));
        csr_prmd_pplv = 2'($urandom_range(0, 3)); csr_prmd_pie = 1'($urandom_range(0, 1));
        csr_eentry = $urandom; csr_era = $urandom;
    endtask

    // Hold a request through one sampling edge, then scramble all inputs.
    task automatic drive(input bit ex, input bit er, input logic [31:0] pc, input logic [5:0] ec,
                         input logic [31:0] va, input logic [1:0] plv, input bit ie,
                         input logic [1:0] pplv, input bit pie, input logic [31:0] ee,
                         input logic [31:0] era);
        wb_ex = ex; ertn_flush = er; wb_pc = pc; wb_ecode = ec; wb_vaddr = va;
        csr_crmd_plv = plv; csr_crmd_ie = ie; csr_prmd_pplv = pplv; csr_prmd_pie = pie;
        csr_eentry = ee; csr_era = era; wb_esubcode = 9'h0;
        @(posedge clk);
        #2 rand_inputs();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rem == 0) break;
        end
        check("idle_timeout_rem", 32'(rem), 32'h0);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        rand_inputs();
        wb_ex = 1'b1; ertn_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_we", 32'(ctl_csr_we), 32'h0);
        check("reset_redirect", 32'(redirect_valid), 32'h0);
        @(posedge clk);
        #2 rand_inputs();
        #1 resetn = 1'b1;
        @(posedge clk);
        #2;

        // SYSCALL, ALE, ADEF, ERTN
        drive(1, 0, 32'h1C000100, 6'h0B, $urandom, 2'd3, 1, 2'd0, 0, 32'h1C008000, $urandom);
        wait_idle();
        drive(1, 0, 32'h1C000200, 6'h09, 32'h80001003, 2'd3, 1, 2'd0, 0, 32'h1C008000, $urandom);
        wait_idle();
        drive(1, 0, 32'h1C000002, 6'h08, 32'h12345678, 2'd0, 0, 2'd1, 1, 32'h1C008000, $urandom);
        wait_idle();
        drive(0, 1, $urandom, 6'h0B, $urandom, 2'd0, 0, 2'd3, 1, $urandom, 32'h1C000104);
        wait_idle();

        // Simultaneous requests, then requests while busy
        drive(1, 1, 32'h1C000300, 6'h0B, $urandom, 2'd2, 0, 2'd1, 1, 32'h1C008000, 32'h1C000400);
        wait_idle();
        drive(1, 0, 32'h1C000500, 6'h09, 32'h00000007, 2'd1, 1, 2'd3, 1, 32'h1C008000, $urandom);
        wb_ex = 1'b1; ertn_flush = 1'b1;
        repeat (2) @(posedge clk);
        #2 rand_inputs();
        wait_idle();

        // Reset during S_PRMD aborts the sequence
        drive(1, 0, 32'h1C000600, 6'h09, 32'hDEADBEE0, 2'd3, 1, 2'd0, 0, 32'h1C008000, $urandom);
        @(posedge clk);
        #1;
        check("prmd_before_reset_num", 32'(ctl_csr_num), 32'(N_PRMD));
        #2 resetn = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_flush", 32'(flush), 32'h0);
        check("abort_we", 32'(ctl_csr_we), 32'h0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        // Randomized traffic; no request is presented in the S_REDIR cycle
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if (rem != 1) begin
                wb_ex = ($urandom_range(0, 5) == 0);
                ertn_flush = ($urandom_range(0, 5) == 0);
            end
            @(posedge clk);
            #2;
        end
        rand_inputs();
        wait_idle();
        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
